// File: rtl/ram_row_reader.sv
// ram_row_reader: streams a contiguous range of RAM words out as row beats.
// Reads run through a two-stage pipeline: address, then RAM data. Each word
// is column-masked and written into a 4-entry FIFO that drives a valid/ready
// stream. Reads are only issued while the FIFO plus in-flight reads hold
// fewer than 4 words, so the FIFO can never overflow.
module ram_row_reader #(
    parameter int AWIDTH      = 10,
    parameter int DWIDTH      = 8,
    parameter int DESIGN_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [AWIDTH-1:0]               base_addr,
    input  logic [AWIDTH:0]                 num_rows,
    input  logic [$clog2(DESIGN_SIZE):0]    valid_cols,
    output logic [AWIDTH-1:0]               ram_addr,
    output logic                            ram_en,
    input  logic [DESIGN_SIZE*DWIDTH-1:0]   ram_q,
    output logic [DESIGN_SIZE*DWIDTH-1:0]   out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    localparam int CW = $clog2(DESIGN_SIZE) + 1;
    localparam int WW = DESIGN_SIZE * DWIDTH;
    localparam logic [CW-1:0]   MAX_COLS = CW'(DESIGN_SIZE);
    localparam logic [AWIDTH:0] ONE_ROW  = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              state_q;
    logic [AWIDTH-1:0]   addr_q;       // next address to issue
    logic [AWIDTH:0]     left_q;       // reads still to issue
    logic [CW-1:0]       cols_q;       // clamped lane count
    logic [AWIDTH-1:0]   ram_addr_q;
    logic                ram_en_q;
    logic                ram_last_q;   // read on the RAM port is the final row
    logic                rd_vld_q;     // ram_q carries data this cycle
    logic                rd_last_q;
    logic                busy_q;
    logic                done_q;

    logic [WW-1:0]       fifo_data_q [4];
    logic [3:0]          fifo_last_q;
    logic [1:0]          wr_ptr_q;
    logic [1:0]          rd_ptr_q;
    logic [2:0]          count_q;

    logic [WW-1:0]       wdata_d;
    logic                pop_d;
    logic                can_issue_d;

    // Zero lanes at or above the programmed column count before storing.
    always_comb begin
        wdata_d = '0;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            if (CW'(i) < cols_q) wdata_d[i*DWIDTH +: DWIDTH] = ram_q[i*DWIDTH +: DWIDTH];
        end
    end

    // Occupancy = stored beats + reads in the address and data stages.
    assign can_issue_d = (count_q + {2'b0, ram_en_q} + {2'b0, rd_vld_q}) < 3'd4;
    assign out_valid   = (count_q != 3'd0);
    assign pop_d       = out_valid & out_ready;
    assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last    = out_valid & fifo_last_q[rd_ptr_q];
    assign ram_addr    = ram_addr_q;
    assign ram_en      = ram_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Command FSM: latches the command, issues reads, finishes on last pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            cols_q     <= '0;
            ram_addr_q <= '0;
            ram_en_q   <= 1'b0;
            ram_last_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ram_en_q   <= 1'b0;
            ram_last_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cols_q <= (valid_cols > MAX_COLS) ? MAX_COLS : valid_cols;
                        if (num_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            // First read goes out on the start edge itself.
                            busy_q     <= 1'b1;
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= base_addr;
                            ram_last_q <= (num_rows == ONE_ROW);
                            addr_q     <= base_addr + 1'b1;
                            left_q     <= num_rows - 1'b1;
                            state_q    <= (num_rows == ONE_ROW) ? S_DRAIN : S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (can_issue_d) begin
                        ram_en_q   <= 1'b1;
                        ram_addr_q <= addr_q;
                        ram_last_q <= (left_q == ONE_ROW);
                        addr_q     <= addr_q + 1'b1;
                        left_q     <= left_q - 1'b1;
                        if (left_q == ONE_ROW) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The tagged last beat is always the final entry to leave.
                    if (pop_d && out_last) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Track which RAM cycle carries data and whether it is the final row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= ram_en_q;
            rd_last_q <= ram_last_q;
        end
    end

    // Output FIFO: push masked RAM data, pop on stream handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) fifo_data_q[i] <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            if (rd_vld_q) begin
                fifo_data_q[wr_ptr_q] <= wdata_d;
                fifo_last_q[wr_ptr_q] <= rd_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop_d) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b0, rd_vld_q} - {2'b0, pop_d};
        end
    end

endmodule

// File: tb/tb_ram_row_reader.sv
// Bench for ram_row_reader: RAM model, random ready, queue-based reference
// model of expected addresses/beats/done/busy checked on every cycle.
module tb_ram_row_reader;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    base_addr = '0;
    logic [10:0]   num_rows = '0;
    logic [4:0]    valid_cols = '0;
    logic [9:0]    ram_addr;
    logic          ram_en;
    logic [127:0]  ram_q = '0;
    logic [127:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [127:0] ram_mem [1024];

    // ready driver control
    bit rmode = 1'b0;
    bit rfix  = 1'b1;

    // reference model state (written only by the compare process)
    logic [9:0]   q_addr [$];
    logic [127:0] q_data [$];
    bit           q_last [$];
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    int           m_issued = 0;
    int           m_popped = 0;
    bit           pv_valid = 1'b0;
    bit           pv_ready = 1'b0;
    bit           pv_last  = 1'b0;
    logic [127:0] pv_data  = '0;
    bit           nd, bb, hs_last;
    int           ce, ma;
    logic [127:0] w;

    ram_row_reader dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .valid_cols(valid_cols), .ram_addr(ram_addr),
        .ram_en(ram_en), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM: data one cycle after the address cycle
    always @(posedge clk) if (ram_en) ram_q <= ram_mem[ram_addr];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // consumer ready: fixed or random, changed just after each edge
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rmode ? 1'($urandom_range(0, 1)) : rfix;
        end
    end

    // compare process: outputs after each edge vs model, then model consumes inputs
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            q_addr.delete(); q_data.delete(); q_last.delete();
            m_busy = 0; m_done = 0; m_issued = 0; m_popped = 0;
            pv_valid = 0; pv_ready = 0; pv_last = 0; pv_data = '0;
        end else begin
            nd = 0; hs_last = 0;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (ram_en) begin
                m_issued++;
                if (q_addr.size() == 0) chk("unexpected_ram_en", ram_en, 0);
                else chk("ram_addr", ram_addr, q_addr.pop_front());
                chk("outstanding_le4", ((m_issued - m_popped) <= 4), 1);
            end
            if (pv_valid && !pv_ready) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pv_data);
                chk("hold_last", out_last, pv_last);
            end
            if (out_valid && out_ready) begin
                m_popped++;
                if (q_data.size() == 0) chk("unexpected_beat", out_valid, 0);
                else begin
                    chk("beat_data", out_data, q_data.pop_front());
                    hs_last = q_last.pop_front();
                    chk("beat_last", out_last, hs_last);
                end
            end
            bb = m_busy;
            if (hs_last) begin m_busy = 0; nd = 1; end
            if (start && !bb) begin
                ce = (valid_cols > 16) ? 16 : int'(valid_cols);
                for (int k = 0; k < int'(num_rows); k++) begin
                    ma = (int'(base_addr) + k) % 1024;
                    w = '0;
                    for (int l = 0; l < 16; l++) if (l < ce) w[l*8 +: 8] = ram_mem[ma][l*8 +: 8];
                    q_addr.push_back(10'(ma));
                    q_data.push_back(w);
                    q_last.push_back(k == int'(num_rows) - 1);
                end
                if (num_rows == 0) nd = 1;
                else m_busy = 1;
            end
            m_done = nd;
            pv_valid = out_valid; pv_ready = out_ready; pv_last = out_last; pv_data = out_data;
        end
    end

    task automatic run_cmd(input logic [9:0] b, input logic [10:0] n, input logic [4:0] c);
        @(posedge clk); #1;
        start = 1; base_addr = b; num_rows = n; valid_cols = c;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < lim);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: got no done within %0d cycles expected done=1", nm, lim);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p0;
        logic [9:0] seen [4];
        logic [9:0] wrap_exp [4];
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;

        for (int i = 0; i < 1024; i++) ram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) ram_mem[5][i*8 +: 8] = 8'(4 * (i + 1));
        for (int i = 0; i < 8; i++)  ram_mem[10][i*8 +: 8] = 8'(8'hFC - 4 * i);
        for (int i = 8; i < 16; i++) ram_mem[10][i*8 +: 8] = 8'hA5;

        #1 resetn = 0;
        #2;
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_out_last", out_last, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1;

        // single row, full width, literal word and latency
        run_cmd(10'h005, 11'd1, 5'd16);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("t1_latency", n, 3);
        chk("t1_data", out_data, 128'h403C3834302C2824201C1814100C0804);
        chk("t1_last", out_last, 1);
        @(negedge clk);
        chk("t1_done", done, 1);

        // column masking
        run_cmd(10'h00A, 11'd1, 5'd8);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("t2_masked", out_data, 128'h0000000000000000E0E4E8ECF0F4F8FC);
        wait_done("t2_done", 20);

        // 32 rows, random backpressure, clamped column count
        rmode = 1;
        p0 = m_popped;
        run_cmd(10'h000, 11'd32, 5'd20);
        wait_done("t3_done", 1000);
        chk("t3_beats", m_popped - p0, 32);
        rmode = 0; rfix = 1;

        // address wrap
        run_cmd(10'h3FE, 11'd4, 5'd16);
        n = 0;
        p0 = 0;
        while (p0 < 4 && n < 30) begin
            if (n > 0) @(negedge clk);
            else @(negedge clk);
            n++;
            if (ram_en) begin seen[p0] = ram_addr; p0++; end
        end
        for (int i = 0; i < 4; i++) chk("t4_wrap_addr", seen[i], wrap_exp[i]);
        wait_done("t4_done", 30);

        // zero rows
        run_cmd(10'h123, 11'd0, 5'd16);
        @(negedge clk);
        chk("t5_zero_done", done, 1);
        chk("t5_zero_ram_en", ram_en, 0);
        chk("t5_zero_busy", busy, 0);

        // start while busy is ignored
        run_cmd(10'h040, 11'd8, 5'd16);
        repeat (2) @(posedge clk);
        #1 start = 1; base_addr = 10'h200; num_rows = 11'd3; valid_cols = 5'd4;
        @(posedge clk); #1 start = 0;
        wait_done("t6_done", 100);
        repeat (3) @(negedge clk);
        chk("t6_no_extra", q_data.size(), 0);

        // reset mid-stream with backpressure
        rfix = 0;
        run_cmd(10'h080, 11'd8, 5'd16);
        repeat (5) @(negedge clk);
        #2 resetn = 0;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_data", out_data, 0);
        chk("t7_rst_ram_en", ram_en, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        rfix = 1;
        repeat (6) @(negedge clk);
        chk("t7_no_done", done, 0);
        run_cmd(10'h090, 11'd5, 5'd16);
        wait_done("t7_after_reset", 50);

        // random commands
        for (int t = 0; t < 12; t++) begin
            rmode = 1'($urandom_range(0, 1));
            run_cmd(10'($urandom_range(0, 1023)), 11'($urandom_range(0, 12)), 5'($urandom_range(0, 31)));
            wait_done("rand_done", 400);
        end
        rmode = 0; rfix = 1;
        repeat (4) @(negedge clk);
        chk("final_drained", q_data.size(), 0);
        chk("final_issue_match", m_issued, m_popped);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
